// File: rtl/scan_disp_mux.sv
// scan_disp_mux: time-multiplexed common-anode seven-segment scanner with per-frame snapshot and guard cycles
module scan_disp_mux #(
    parameter int N_DIGITS    = 8,
    parameter int D_WIDTH     = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD_CYC   = 2000,
    localparam int SEL_W      = $clog2(N_DIGITS)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [N_DIGITS*D_WIDTH-1:0] digits,
    input  logic [N_DIGITS-1:0]         dp_in,
    input  logic [N_DIGITS-1:0]         blank_mask,
    output logic [SEL_W-1:0]            sel,
    output logic [N_DIGITS-1:0]         anode_n,
    output logic [D_WIDTH-1:0]          y,
    output logic                        dp_n,
    output logic                        frame_start
);
    localparam int P_W = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam logic [P_W-1:0]      LAST     = P_W'(REFRESH_DIV - 1);
    localparam logic [P_W-1:0]      GUARD_N  = P_W'(GUARD_CYC);
    localparam logic [SEL_W-1:0]    LAST_SEL = SEL_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] ONE      = N_DIGITS'(1);

    typedef enum logic [1:0] {IDLE, GUARD, ON} state_t;

    state_t                      state, state_nx;
    logic [P_W-1:0]              presc, presc_nx;
    logic [SEL_W-1:0]            sel_nx;
    logic                        wrap, load, lit;
    logic [N_DIGITS*D_WIDTH-1:0] snap_digits;
    logic [N_DIGITS-1:0]         snap_dp, snap_blank;
    logic [N_DIGITS-1:0]         anode_nx;
    logic [D_WIDTH-1:0]          y_nx;
    logic                        dp_nx;

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // next state: disable always parks in IDLE; otherwise the prescaler position picks GUARD or ON
    always_comb begin
        wrap     = presc == LAST;
        presc_nx = (state == IDLE || !enable || wrap) ? '0 : presc + 1'b1;
        sel_nx   = (state == IDLE || !enable) ? '0 : wrap ? (sel == LAST_SEL ? '0 : sel + 1'b1) : sel;
        load     = enable && (state == IDLE || (wrap && sel == LAST_SEL));
        state_nx = !enable ? IDLE : (presc_nx < GUARD_N ? GUARD : ON);
    end

    // prescaler, digit index and the frame snapshot, reloaded only at frame boundaries
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc       <= '0;
            sel         <= '0;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_blank  <= '0;
            frame_start <= 1'b0;
        end else begin
            presc       <= presc_nx;
            sel         <= sel_nx;
            frame_start <= load;
            if (load) begin
                snap_digits <= digits;
                snap_dp     <= dp_in;
                snap_blank  <= blank_mask;
            end
        end
    end

    assign lit = state == ON && !snap_blank[sel];

    // outputs: digit code settles during guard, anode and dp only while lit
    always_comb begin
        anode_nx = lit ? ~(ONE << sel) : '1;
        y_nx     = state == IDLE ? '0 : snap_digits[sel*D_WIDTH +: D_WIDTH];
        dp_nx    = lit ? ~snap_dp[sel] : 1'b1;
    end

    // registered outputs, one cycle behind the scan state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            anode_n <= '1;
            y       <= '0;
            dp_n    <= 1'b1;
        end else begin
            anode_n <= anode_nx;
            y       <= y_nx;
            dp_n    <= dp_nx;
        end
    end
endmodule

// File: tb/tb_scan_disp_mux.sv
// tb_scan_disp_mux: scoreboard bench for scan_disp_mux against a frame-position model
module tb_scan_disp_mux;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] digits = '0;
    logic [7:0]  dp_in = '0;
    logic [7:0]  blank_mask = '0;
    logic [2:0]  sel;
    logic [7:0]  anode_n;
    logic [3:0]  y;
    logic        dp_n;
    logic        frame_start;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    bit          m_on;
    int          m_t;
    logic [31:0] m_sd;
    logic [7:0]  m_sdp, m_sbl;

    scan_disp_mux #(.N_DIGITS(8), .D_WIDTH(4), .REFRESH_DIV(8), .GUARD_CYC(2)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .digits(digits), .dp_in(dp_in),
        .blank_mask(blank_mask), .sel(sel), .anode_n(anode_n), .y(y), .dp_n(dp_n),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // model: frame position 0..63, slot = t/8, phase = t%8, lit from phase 2
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_on = 0; m_t = 0; m_sd = '0; m_sdp = '0; m_sbl = '0;
            exp_q.delete();
        end else begin
            int slot, ph;
            bit lit, fs;
            logic [7:0] a;
            logic [3:0] ey;
            logic ed;
            slot = m_t / 8;
            ph   = m_t % 8;
            lit  = m_on && ph >= 2 && !m_sbl[slot];
            a    = lit ? ~(8'h01 << slot) : 8'hFF;
            ey   = m_on ? 4'((m_sd >> (4 * slot)) & 32'hF) : 4'h0;
            ed   = lit ? ~m_sdp[slot] : 1'b1;
            fs   = 0;
            if (!enable) begin
                m_on = 0; m_t = 0;
            end else if (!m_on || m_t == 63) begin
                m_on = 1; m_t = 0; fs = 1;
                m_sd = digits; m_sdp = dp_in; m_sbl = blank_mask;
            end else m_t++;
            exp_q.push_back({15'd0, a, ey, ed, 3'(m_on ? m_t / 8 : 0), fs});
        end
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) chk("scan", {15'd0, anode_n, y, dp_n, sel, frame_start}, exp_q.pop_front());
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        @(negedge clk);
        chk("rst_anode", {24'd0, anode_n}, 32'hFF);
        chk("rst_misc", {27'd0, y, dp_n}, 32'h1);
        chk("rst_sel_fs", {28'd0, sel, frame_start}, 32'h0);
        cyc(2);
        reset_n = 1'b1;
        cyc(20);
        digits = 32'h76543210;
        enable = 1'b1;
        cyc(1);
        cyc(64);
        cyc(20);
        digits = 32'hFFFFFFFF;
        cyc(44);
        cyc(64);
        blank_mask = 8'h81;
        dp_in = 8'h04;
        digits = 32'hA5C3E1B7;
        cyc(64);
        cyc(64);
        cyc(29);
        enable = 1'b0;
        cyc(3);
        chk("drop_anode", {24'd0, anode_n}, 32'hFF);
        digits = 32'h89ABCDEF;
        blank_mask = 8'h00;
        dp_in = 8'hFF;
        enable = 1'b1;
        cyc(1);
        cyc(45);
        #4;
        reset_n = 1'b0;
        #1;
        chk("async_anode", {24'd0, anode_n}, 32'hFF);
        chk("async_sel_fs", {28'd0, sel, frame_start}, 32'h0);
        chk("async_y_dp", {27'd0, y, dp_n}, 32'h1);
        #2;
        reset_n = 1'b1;
        cyc(1);
        cyc(63);
        enable = 1'b0;
        cyc(3);
        chk("wrap_drop_fs", {31'd0, frame_start}, 32'h0);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
